// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact/approximate mode.
// Low x rows drop product columns below KEEP_COL; valid/ready stream with a global stall.
module approx_mult_pipe #(
  parameter int unsigned W        = 8,
  parameter int unsigned L        = 4,
  parameter int unsigned KEEP_COL = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   z,
  output logic             z_exact,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] x_ext, y_ext;
  logic [PW-1:0] hi_d, lo_d, pp;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ex_q;
  logic [PW-1:0]     hi_q [STAGES];
  logic [PW-1:0]     lo_q [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;

  // Partial-product generation: high rows (or the whole product) plus the kept low-row bits.
  always_comb begin
    x_ext = PW'(x);
    y_ext = PW'(y);
    hi_d  = '0;
    lo_d  = '0;
    pp    = '0;
    if (exact) begin
      hi_d = x_ext * y_ext;
    end else begin
      hi_d = (y_ext * (x_ext >> L)) << L;
      for (int i = 0; i < int'(L); i++) begin
        for (int j = 0; j < int'(W); j++) begin
          if (i + j >= int'(KEEP_COL)) begin
            pp        = '0;
            pp[i + j] = x[i] & y[j];
            lo_d      = lo_d + pp;
          end
        end
      end
    end
  end

  assign stall    = vld_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ex_q  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        hi_q[k] <= '0;
        lo_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        ex_q[0] <= exact;
        hi_q[0] <= hi_d;
        lo_q[0] <= lo_d;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        vld_q[k] <= vld_q[k-1];
        ex_q[k]  <= ex_q[k-1];
        hi_q[k]  <= hi_q[k-1];
        lo_q[k]  <= lo_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_q[STAGES-1] && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Final row reduction sits after the last slot, so z is stable while stalled.
  assign out_valid = vld_q[STAGES-1];
  assign z         = hi_q[STAGES-1] + lo_q[STAGES-1];
  assign z_exact   = ex_q[STAGES-1];
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: directed vectors, stream/stall/reset sequences,
// and random sweeps on two other parameter sets against a reference model.
module tb_approx_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: high rows as one product, each low row as y<<i with columns below k cleared.
  function automatic longint unsigned model(input longint unsigned xv, input longint unsigned yv,
                                            input bit ex, input int l, input int k);
    longint unsigned r;
    if (ex) return xv * yv;
    r = (yv * (xv >> l)) << l;
    for (int i = 0; i < l; i++) begin
      if (((xv >> i) & 64'd1) != 0) r += (((yv << i) >> k) << k);
    end
    return r;
  endfunction

  // ---------------- main instance: W=8, L=4, KEEP_COL=8, STAGES=2 ----------------
  logic        rst, in_valid, in_ready, exact, out_valid, out_ready, z_exact;
  logic [7:0]  x, y;
  logic [15:0] z;
  logic [31:0] txn_count;

  approx_mult_pipe #(.W(8), .L(4), .KEEP_COL(8), .STAGES(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .exact(exact), .out_valid(out_valid), .out_ready(out_ready), .z(z), .z_exact(z_exact),
    .txn_count(txn_count)
  );

  logic [16:0]     qa [$];
  logic [16:0]     ea;
  longint unsigned ma;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("a_output_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("a_z", 64'(z), 64'(ea[15:0]));
          check("a_z_exact", 64'(z_exact), 64'(ea[16]));
        end
      end
      if (in_valid && in_ready) begin
        ma = model(64'(x), 64'(y), exact, 4, 8);
        qa.push_back({exact, ma[15:0]});
      end
    end
  end

  // ---------------- sweep B: W=16, L=8, KEEP_COL=16, STAGES=4 ----------------
  logic        b_rst, b_in_valid, b_in_ready, b_exact, b_out_valid, b_out_ready, b_z_exact;
  logic [15:0] b_x, b_y;
  logic [31:0] b_z;
  logic [31:0] b_txn;
  int          nacc_b = 0;
  bit          done_b = 1'b0;

  approx_mult_pipe #(.W(16), .L(8), .KEEP_COL(16), .STAGES(4), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .y(b_y),
    .exact(b_exact), .out_valid(b_out_valid), .out_ready(b_out_ready), .z(b_z),
    .z_exact(b_z_exact), .txn_count(b_txn)
  );

  logic [32:0]     qb [$];
  logic [32:0]     eb;
  longint unsigned mb;

  always @(negedge clk) begin
    if (b_rst) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        check("b_output_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("b_z", 64'(b_z), 64'(eb[31:0]));
          check("b_z_exact", 64'(b_z_exact), 64'(eb[32]));
        end
      end
      if (b_in_valid && b_in_ready) begin
        mb = model(64'(b_x), 64'(b_y), b_exact, 8, 16);
        qb.push_back({b_exact, mb[31:0]});
        nacc_b++;
      end
    end
  end

  // ---------------- sweep C: W=8, L=0, KEEP_COL=3, STAGES=1, CNT_W=3 ----------------
  logic        c_rst, c_in_valid, c_in_ready, c_exact, c_out_valid, c_out_ready, c_z_exact;
  logic [7:0]  c_x, c_y;
  logic [15:0] c_z;
  logic [2:0]  c_txn;
  int          nacc_c = 0;
  int          nhs_c  = 0;
  bit          done_c = 1'b0;

  approx_mult_pipe #(.W(8), .L(0), .KEEP_COL(3), .STAGES(1), .CNT_W(3)) u_dut_c (
    .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .x(c_x), .y(c_y),
    .exact(c_exact), .out_valid(c_out_valid), .out_ready(c_out_ready), .z(c_z),
    .z_exact(c_z_exact), .txn_count(c_txn)
  );

  logic [16:0] qc [$];
  logic [16:0] ec;
  logic [15:0] mc;

  always @(negedge clk) begin
    if (c_rst) begin
      qc.delete();
    end else begin
      if (c_out_valid && c_out_ready) begin
        nhs_c++;
        check("c_output_expected", 64'(qc.size() != 0), 64'd1);
        if (qc.size() != 0) begin
          ec = qc.pop_front();
          check("c_z", 64'(c_z), 64'(ec[15:0]));
          check("c_z_exact", 64'(c_z_exact), 64'(ec[16]));
        end
      end
      if (c_in_valid && c_in_ready) begin
        // With no approximated rows both modes reduce to the plain product.
        mc = c_x * c_y;
        qc.push_back({c_exact, mc});
        nacc_c++;
      end
    end
  end

  initial begin
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_exact = 1'b0;
    tick(); tick();
    b_rst = 1'b0;
    for (int cyc = 0; cyc < 30000 && nacc_b < 10000; cyc++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_x         = 16'($urandom);
      b_y         = 16'($urandom);
      b_exact     = 1'($urandom_range(0, 1));
      tick();
    end
    check("b_vector_budget", 64'(nacc_b >= 10000), 64'd1);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (10) tick();
    check("b_drained", 64'(qb.size()), 64'd0);
    done_b = 1'b1;
  end

  initial begin
    c_rst = 1'b1; c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0; c_exact = 1'b0;
    tick(); tick();
    c_rst = 1'b0;
    check("c_reset_count", 64'(c_txn), 64'd0);
    for (int cyc = 0; cyc < 30000 && nacc_c < 10000; cyc++) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_x         = 8'($urandom);
      c_y         = 8'($urandom);
      c_exact     = 1'($urandom_range(0, 1));
      tick();
    end
    check("c_vector_budget", 64'(nacc_c >= 10000), 64'd1);
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    repeat (6) tick();
    check("c_drained", 64'(qc.size()), 64'd0);
    check("c_count_wrap", 64'(c_txn), 64'(nhs_c % 8));
    done_c = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ex;
    logic [15:0] z;
  } vec_t;

  vec_t vt [10];
  logic [15:0] zs;

  initial begin
    vt[0] = '{x: 8'd255, y: 8'd255, ex: 1'b0, z: 16'd64016};
    vt[1] = '{x: 8'd255, y: 8'd255, ex: 1'b1, z: 16'd65025};
    vt[2] = '{x: 8'd15,  y: 8'd255, ex: 1'b0, z: 16'd2816};
    vt[3] = '{x: 8'd15,  y: 8'd255, ex: 1'b1, z: 16'd3825};
    vt[4] = '{x: 8'd240, y: 8'd200, ex: 1'b0, z: 16'd48000};
    vt[5] = '{x: 8'd240, y: 8'd200, ex: 1'b1, z: 16'd48000};
    vt[6] = '{x: 8'd1,   y: 8'd1,   ex: 1'b0, z: 16'd0};
    vt[7] = '{x: 8'd1,   y: 8'd1,   ex: 1'b1, z: 16'd1};
    vt[8] = '{x: 8'd16,  y: 8'd16,  ex: 1'b0, z: 16'd256};
    vt[9] = '{x: 8'd8,   y: 8'd255, ex: 1'b0, z: 16'd1792};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; exact = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_z", 64'(z), 64'd0);
    check("reset_z_exact", 64'(z_exact), 64'd0);
    check("reset_txn_count", 64'(txn_count), 64'd0);

    for (int v = 0; v < 10; v++) begin
      x = vt[v].x; y = vt[v].y; exact = vt[v].ex; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("latency_not_early", 64'(out_valid), 64'd0);
      tick();
      check("latency_valid", 64'(out_valid), 64'd1);
      check("table_z", 64'(z), 64'(vt[v].z));
      check("table_z_exact", 64'(z_exact), 64'(vt[v].ex));
      tick();
    end
    check("table_txn_count", 64'(txn_count), 64'd10);

    // Back-to-back stream of eight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        x = 8'($urandom); y = 8'($urandom); exact = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) check("stream_one_per_cycle", 64'(out_valid), 64'd1);
      if (c == 9) check("stream_ended", 64'(out_valid), 64'd0);
    end
    check("stream_txn_count", 64'(txn_count), 64'd8);

    // Fill the pipe, then hold out_ready low for five cycles.
    out_ready = 1'b0;
    x = 8'($urandom); y = 8'($urandom); exact = 1'b0; in_valid = 1'b1;
    tick();
    x = 8'($urandom); y = 8'($urandom); exact = 1'b1;
    tick();
    check("stall_in_ready", 64'(in_ready), 64'd0);
    zs = z;
    for (int s = 0; s < 5; s++) begin
      x = 8'($urandom); y = 8'($urandom); exact = 1'($urandom_range(0, 1));
      tick();
      check("stall_in_ready_hold", 64'(in_ready), 64'd0);
      check("stall_out_valid_hold", 64'(out_valid), 64'd1);
      check("stall_z_stable", 64'(z), 64'(zs));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("stall_all_delivered", 64'(qa.size()), 64'd0);
    check("stall_txn_count", 64'(txn_count), 64'd11);

    // Reset with two transactions in flight; the input on the reset edge is dropped.
    x = 8'd255; y = 8'd255; exact = 1'b0; in_valid = 1'b1;
    tick();
    x = 8'd15;
    tick();
    rst = 1'b1; x = 8'd240;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_flight_out_valid", 64'(out_valid), 64'd0);
    check("rst_flight_txn_count", 64'(txn_count), 64'd0);
    check("rst_flight_in_ready", 64'(in_ready), 64'd1);
    for (int s = 0; s < 6; s++) begin
      tick();
      check("rst_no_stale_output", 64'(out_valid), 64'd0);
    end
    check("rst_txn_count_still_zero", 64'(txn_count), 64'd0);

    wait (done_b && done_c);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 level-4 approximate unsigned multiplier.
- Operand width, approximation depth and kept-column threshold are parameters.
- A per-transaction mode bit selects exact or approximate product.
- Sits in the datapath behind a valid/ready stream with backpressure, and keeps a completed-transaction counter for characterisation benches.

Parameters:
- W, 8, operand width in bits (W >= 4).
- L, 4, number of low x rows (x[L-1:0]) that are approximated (0 <= L < W).
- KEEP_COL, 8, lowest product column kept from approximated rows (0 <= KEEP_COL <= W+L-2).
- STAGES, 2, pipeline depth in cycles (1..4).
- CNT_W, 32, width of the transaction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept the input this cycle.
- x  in  W  multiplicand (unsigned).
- y  in  W  multiplier (unsigned).
- exact  in  1  1 = exact product; 0 = approximate product.
- out_valid  out  1  z is valid.
- out_ready  in  1  downstream accepts z.
- z  out  2W  product (unsigned).
- z_exact  out  1  mode bit that travelled with this z.
- txn_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Arithmetic, approximate mode (exact=0):
  - z = ((y * x[W-1:L]) << L) + A.
  - A = sum over i in [0,L), j in [0,W) with i+j >= KEEP_COL of (x[i] & y[j]) << (i+j).
  - Low-row bits in columns below KEEP_COL are dropped.
  - No compensation constant is added.
  - Full 2W-bit sum; no overflow is possible.
- Arithmetic, exact mode (exact=1): z = x * y.
- L=0: both modes give the exact product.
- Pipeline:
  - STAGES registered slots, each holding a valid bit plus payload.
  - Partial-product generation and row reduction may be split across stages freely; only the final z and the latency are normative.
- Handshake:
  - Input is accepted when in_valid & in_ready.
  - Output completes when out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - When stall=1, all slots hold their contents and no data is lost or duplicated.
  - When stall=0, every slot advances one stage.
  - A slot fed from an idle input becomes a bubble (valid=0).
- Latency:
  - An input accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. on the cycle following the STAGES-th rising edge counted from acceptance, provided there are no stalls.
  - Each stall cycle adds one cycle.
  - Order is preserved.
- Throughput: one result per cycle while out_ready=1.
- z and z_exact are stable while out_valid=1 and out_ready=0.
- Payload with out_valid=0 is don't-care.
- x, y and exact are sampled only on an input handshake; changes while in_ready=0 have no effect.
- txn_count:
  - Increments by 1 on each output handshake.
  - Wraps from 2^CNT_W-1 to 0.
- Reset (synchronous):
  - On the edge where rst=1, all valid bits clear.
  - out_valid=0, z=0, z_exact=0, txn_count=0.
  - in_ready=1 from the next cycle.
  - In-flight transactions are discarded, with no output.
- Simultaneous in_valid and rst: the input is dropped.

Test Plan:
- W=8, L=4, KEEP_COL=8, exact=0, x=255, y=255:
  - z=64016 (high part 61200 + A=2816).
  - z_exact=0.
  - out_valid 2 cycles after acceptance (STAGES=2).
  - The same operands with exact=1 give z=65025.
- exact=0, x=15, y=255 -> z=2816. Same operands with exact=1 -> z=3825. x=240, y=200 -> z=48000 in both modes.
- Back-to-back stream of 8 transactions with out_ready held 1:
  - One z per cycle, in order.
  - txn_count=8 afterwards.
- Stall handling:
  - Hold out_ready=0 for 5 cycles with the pipe full: in_ready=0, z unchanged.
  - Release: all results are delivered, no loss or duplication.
- Assert rst with 2 transactions in flight:
  - Next cycle out_valid=0, txn_count=0, in_ready=1.
  - No stale output appears afterwards.
- Parameter sweeps, each against a golden model on 10k random vectors:
  - W=16, L=8, KEEP_COL=16, STAGES=4: exact mode matches x*y; approximate mode matches the formula.
  - L=0: approximate mode equals exact mode.
